// File: rtl/uwasic_onboarding_punchdii.sv
// SPI-programmable 16-channel output/PWM controller (Tiny Tapeout user top).
// A write-only SPI mode-0 slave loads enable, PWM-select and duty registers.
module uwasic_onboarding_punchdii #(
  parameter int unsigned PWM_PERIOD = 3333,
  parameter int unsigned NUM_REGS   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = $clog2(PWM_PERIOD);

  // Synchronizer stages: [1] is the synced value, [2] is its previous value for edge detect.
  logic [2:0]      r_sclk_sync;
  logic [1:0]      r_copi_sync;
  logic [2:0]      r_ncs_sync;
  logic [15:0]     r_shift;
  logic [4:0]      r_bit_cnt;
  logic [15:0]     r_en_out;
  logic [15:0]     r_en_pwm;
  logic [7:0]      r_duty;
  logic [CntW-1:0] r_pwm_cnt;
  logic [15:0]     r_out;

  logic            w_sclk_rise;
  logic            w_ncs_fall;
  logic            w_ncs_rise;
  logic [6:0]      w_addr;
  logic            w_commit;
  logic [19:0]     w_thresh;
  logic            w_pwm;
  logic [15:0]     w_out;
  logic            w_unused;

  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], ui_in[0]};
      r_copi_sync <= {r_copi_sync[0], ui_in[1]};
      r_ncs_sync  <= {r_ncs_sync[1:0], ui_in[2]};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_sync[2];
  assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_ncs_fall) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (!r_ncs_sync[1] && w_sclk_rise && (r_bit_cnt != 5'd16)) begin
      r_shift   <= {r_shift[14:0], r_copi_sync[1]};
      r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  assign w_addr   = r_shift[14:8];
  assign w_commit = w_ncs_rise && (r_bit_cnt == 5'd16) && r_shift[15] &&
                    (32'(w_addr) < NUM_REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_out <= '0;
      r_en_pwm <= '0;
      r_duty   <= '0;
    end else if (w_commit) begin
      case (w_addr)
        7'h00:   r_en_out[7:0]  <= r_shift[7:0];
        7'h01:   r_en_out[15:8] <= r_shift[7:0];
        7'h02:   r_en_pwm[7:0]  <= r_shift[7:0];
        7'h03:   r_en_pwm[15:8] <= r_shift[7:0];
        7'h04:   r_duty         <= r_shift[7:0];
        default: ;
      endcase
    end
  end

  // Free-running; a duty change never restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == CntW'(PWM_PERIOD - 1)) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + CntW'(1);
    end
  end

  assign w_thresh = (20'(r_duty) * 20'(PWM_PERIOD)) >> 8;
  assign w_pwm    = (r_duty == 8'hFF) ? 1'b1 : (20'(r_pwm_cnt) < w_thresh);

  always_comb begin
    w_out = '0;
    for (int i = 0; i < 16; i++) begin
      w_out[i] = r_en_out[i] & (r_en_pwm[i] ? w_pwm : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_out;
    end
  end

  assign uo_out  = r_out[7:0];
  assign uio_out = r_out[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_punchdii.sv
// Directed self-checking bench for the SPI-programmed output/PWM controller.
module tb_uwasic_onboarding_punchdii;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int hi;
  int per;
  int ones;

  uwasic_onboarding_punchdii dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SCLK phases of 5 clk each; bits past 16 are driven as 1.
  task automatic spi_xfer(input logic [15:0] w, input int nbits);
    ui_in[2] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = (i < 16) ? w[15-i] : 1'b1;
      repeat (5) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (5) @(negedge clk);
      ui_in[0] = 1'b0;
    end
    repeat (5) @(negedge clk);
    ui_in[2] = 1'b1;
    ui_in[1] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // High time and period of uo_out[0], starting from a rising edge; bounded.
  task automatic measure(output int h, output int p);
    int lo;
    int guard;
    h = 0;
    lo = 0;
    guard = 0;
    while (uo_out[0] !== 1'b0 && guard < 5000) begin @(negedge clk); guard++; end
    while (uo_out[0] !== 1'b1 && guard < 10000) begin @(negedge clk); guard++; end
    while (uo_out[0] === 1'b1 && guard < 15000) begin @(negedge clk); guard++; h++; end
    while (uo_out[0] === 1'b0 && guard < 20000) begin @(negedge clk); guard++; lo++; end
    p = h + lo;
  endtask

  task automatic count_ones(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0] === 1'b1) c++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h04;
    uio_in = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uo", 32'(uo_out), 32'h00);
    check("rst_uio", 32'(uio_out), 32'h00);
    check("rst_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_uo", 32'(uo_out), 32'h00);
    check("idle_uio", 32'(uio_out), 32'h00);

    // Static-high writes
    spi_xfer(16'h80F0, 16);
    spi_xfer(16'h81CC, 16);
    check("static_uo", 32'(uo_out), 32'hF0);
    check("static_uio", 32'(uio_out), 32'hCC);

    // Read frame and out-of-range address are discarded
    spi_xfer(16'h00FF, 16);
    check("read_uo", 32'(uo_out), 32'hF0);
    spi_xfer(16'hB0FF, 16);
    check("oor_uo", 32'(uo_out), 32'hF0);
    check("oor_uio", 32'(uio_out), 32'hCC);

    // PWM on channel 0
    spi_xfer(16'h8001, 16);
    spi_xfer(16'h8201, 16);
    spi_xfer(16'h8480, 16);
    check("pwm_others", 32'(uo_out & 8'hFE), 32'h00);
    measure(hi, per);
    check("pwm80_high", 32'(hi), 32'd1666);
    check("pwm80_period", 32'(per), 32'd3333);
    spi_xfer(16'h8401, 16);
    measure(hi, per);
    check("pwm01_high", 32'(hi), 32'd13);
    check("pwm01_period", 32'(per), 32'd3333);
    spi_xfer(16'h84FE, 16);
    measure(hi, per);
    check("pwmFE_high", 32'(hi), 32'd3306);
    spi_xfer(16'h8400, 16);
    count_ones(3400, ones);
    check("pwm00_const0", 32'(ones), 32'd0);
    spi_xfer(16'h84FF, 16);
    count_ones(3400, ones);
    check("pwmFF_const1", 32'(ones), 32'd3400);
    check("pwm_uio", 32'(uio_out), 32'hCC);

    // Aborted / short / over-long frames
    spi_xfer(16'h8133, 8);
    check("abort8_uio", 32'(uio_out), 32'hCC);
    spi_xfer(16'h8133, 16);
    check("after_abort_uio", 32'(uio_out), 32'h33);
    spi_xfer(16'h81AA, 15);
    check("short15_uio", 32'(uio_out), 32'h33);
    spi_xfer(16'h8155, 17);
    check("long17_uio", 32'(uio_out), 32'h55);

    // Reset mid-PWM and mid-transaction
    spi_xfer(16'h80FF, 16);
    spi_xfer(16'h820F, 16);
    spi_xfer(16'h8480, 16);
    ui_in[2] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ui_in[1] = 1'b1;
      repeat (5) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (5) @(negedge clk);
      ui_in[0] = 1'b0;
    end
    check("pre_rst_uio", 32'(uio_out), 32'h55);
    #13 rst_n = 1'b0;
    #1;
    check("async_rst_uo", 32'(uo_out), 32'h00);
    check("async_rst_uio", 32'(uio_out), 32'h00);
    check("async_rst_oe", 32'(uio_oe), 32'hFF);
    ui_in = 8'h04;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_uo", 32'(uo_out), 32'h00);
    check("post_rst_uio", 32'(uio_out), 32'h00);
    spi_xfer(16'h80FF, 16);
    spi_xfer(16'h81FF, 16);
    check("post_rst_enpwm_uo", 32'(uo_out), 32'hFF);
    check("post_rst_enpwm_uio", 32'(uio_out), 32'hFF);
    spi_xfer(16'h82FF, 16);
    check("post_rst_duty_uo", 32'(uo_out), 32'h00);
    check("post_rst_duty_uio", 32'(uio_out), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
